// File: rtl/gamecntl_pkg.sv
// Shared types and constants for the Space Race coin/credit and game-sequence controller.
package gamecntl_pkg;

  typedef enum logic [2:0] {ATTRACT, TRIG, WAIT_ACK, PLAY, GAME_OVER} gc_state_t;

  localparam int unsigned CREDIT_W = 4;

endpackage

// File: rtl/gamecntl_if.sv
// Cabinet-side signal bundle of the game controller: switches, timer handshake and status.
interface gamecntl_if;
  import gamecntl_pkg::*;

  logic                COIN_N;
  logic                START_N;
  logic                FREE_PLAY;
  logic                C9_OUT;
  logic                TRG_C9_N;
  logic                TRG_D9_N;
  logic                ATTRACT_N;
  logic                GAME_ON;
  logic                SCORE_CLR;
  logic [CREDIT_W-1:0] CREDITS;

  modport master (
    output COIN_N, START_N, FREE_PLAY, C9_OUT,
    input  TRG_C9_N, TRG_D9_N, ATTRACT_N, GAME_ON, SCORE_CLR, CREDITS
  );

  modport slave (
    input  COIN_N, START_N, FREE_PLAY, C9_OUT,
    output TRG_C9_N, TRG_D9_N, ATTRACT_N, GAME_ON, SCORE_CLR, CREDITS
  );

endinterface

// File: rtl/input_debounce.sv
// Two-flop synchronizer plus counting debouncer for an active-low switch; emits a one-cycle
// press pulse when the debounced level falls.
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din_n,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic            sync1_q, sync2_q, stable_q, press_q;
  logic [CntW-1:0] cnt_q;

  // cnt_q counts consecutive synchronized samples that disagree with the stable level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q <= din_n;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
        press_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/gamecntl_fsm.sv
// Coin/credit and game-sequence controller: triggers the playtime and fuel-bar timers and
// tracks the game through attract, trigger, acknowledge, play and game-over phases.
module gamecntl_fsm
  import gamecntl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned CREDIT_MAX   = 9,
  parameter int unsigned TRG_W        = 4,
  parameter int unsigned ACK_TO       = 1024,
  parameter int unsigned GO_CYC       = 4096
) (
  input logic       CLK_DRV,
  input logic       RST,
  gamecntl_if.slave bus
);

  localparam int unsigned TrgCntW = $clog2(TRG_W + 1);
  localparam int unsigned AckCntW = $clog2(ACK_TO + 1);
  localparam int unsigned GoCntW  = $clog2(GO_CYC + 1);

  gc_state_t           state_q, state_d;
  logic [TrgCntW-1:0]  trg_cnt_q;
  logic [AckCntW-1:0]  ack_cnt_q;
  logic [GoCntW-1:0]   go_cnt_q;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic                c9_q, c9_prev_q;
  logic                coin_press, start_press, consume;

  input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_coin_db (
    .clk   (CLK_DRV),
    .rst   (RST),
    .din_n (bus.COIN_N),
    .press (coin_press)
  );

  input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_db (
    .clk   (CLK_DRV),
    .rst   (RST),
    .din_n (bus.START_N),
    .press (start_press)
  );

  // Phase counters run only while their state persists, so they restart from zero on entry.
  always_ff @(posedge CLK_DRV) begin
    if (RST) begin
      state_q   <= ATTRACT;
      trg_cnt_q <= '0;
      ack_cnt_q <= '0;
      go_cnt_q  <= '0;
      credits_q <= '0;
      c9_q      <= 1'b0;
      c9_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      c9_q      <= bus.C9_OUT;
      c9_prev_q <= c9_q;
      trg_cnt_q <= (state_q == TRIG && state_d == TRIG) ? trg_cnt_q + TrgCntW'(1) : '0;
      ack_cnt_q <= (state_q == WAIT_ACK && state_d == WAIT_ACK) ? ack_cnt_q + AckCntW'(1) : '0;
      go_cnt_q  <= (state_q == GAME_OVER && state_d == GAME_OVER) ? go_cnt_q + GoCntW'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ATTRACT: begin
        if (start_press && (credits_q != '0 || bus.FREE_PLAY)) state_d = TRIG;
      end
      TRIG: begin
        if (trg_cnt_q == TrgCntW'(TRG_W - 1)) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (c9_q)                                    state_d = PLAY;
        else if (ack_cnt_q == AckCntW'(ACK_TO - 1)) state_d = GAME_OVER;
      end
      PLAY: begin
        if (c9_prev_q && !c9_q) state_d = GAME_OVER;
      end
      GAME_OVER: begin
        if (go_cnt_q == GoCntW'(GO_CYC - 1)) state_d = ATTRACT;
      end
      default: state_d = ATTRACT;
    endcase

    consume   = (state_q == ATTRACT) && (state_d == TRIG) && !bus.FREE_PLAY;
    credits_d = credits_q;
    if (coin_press && !consume) begin
      if (credits_q != CREDIT_W'(CREDIT_MAX)) credits_d = credits_q + CREDIT_W'(1);
    end else if (consume && !coin_press) begin
      credits_d = credits_q - CREDIT_W'(1);
    end else if (consume && coin_press && credits_q == CREDIT_W'(CREDIT_MAX)) begin
      // Saturated counter cannot absorb the coin, so only the consumption lands.
      credits_d = credits_q - CREDIT_W'(1);
    end
  end

  always_comb begin
    bus.TRG_C9_N  = (state_q != TRIG);
    bus.TRG_D9_N  = (state_q != TRIG);
    bus.ATTRACT_N = (state_q != ATTRACT);
    bus.GAME_ON   = (state_q == PLAY);
    bus.SCORE_CLR = (state_q == TRIG) && (trg_cnt_q == '0);
    bus.CREDITS   = credits_q;
  end

endmodule

// File: tb/tb_gamecntl_fsm.sv
// Directed and randomized bench for gamecntl_fsm against a phase-level model of credits and timing.
module tb_gamecntl_fsm;

  localparam int D      = 16;
  localparam int CMAX   = 9;
  localparam int TRG_W  = 4;
  localparam int ACK_TO = 1024;
  localparam int GO_CYC = 4096;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   m_credits = 0;
  bit   m_fp = 1'b0;

  gamecntl_if bus ();

  gamecntl_fsm dut (
    .CLK_DRV (clk),
    .RST     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic coin_press(input int width, input bit glitch);
    bus.COIN_N = 1'b0;
    tick(width);
    bus.COIN_N = 1'b1;
    tick(D + 4);
    if (!glitch) m_credits = sat_inc(m_credits);
    chk(glitch ? "credits_after_glitch" : "credits_after_coin", 32'(bus.CREDITS), m_credits);
  endtask

  // Presses start (optionally with a coin at the same instant) and checks the trigger pulse.
  task automatic try_start(input bit exp_fire, input bit with_coin);
    int lat, lowcnt, sc_tot, skew;
    bit fired, sc_first;
    bus.START_N = 1'b0;
    if (with_coin) bus.COIN_N = 1'b0;
    lat = 0;
    fired = 1'b0;
    while (!fired && lat < D + 10) begin
      tick(1);
      lat++;
      if (bus.TRG_C9_N === 1'b0) fired = 1'b1;
    end
    if (exp_fire) begin
      chk("trig_fires", 32'(fired), 1);
      if (fired) begin
        chk("trig_latency", lat, D + 3);
        sc_first = bus.SCORE_CLR;
        lowcnt = 0;
        sc_tot = 0;
        skew = 0;
        while (bus.TRG_C9_N === 1'b0 && lowcnt < 20) begin
          lowcnt++;
          sc_tot += int'(bus.SCORE_CLR);
          if (bus.TRG_D9_N !== 1'b0) skew++;
          chk("attract_n_in_trig", 32'(bus.ATTRACT_N), 1);
          tick(1);
        end
        chk("trig_width", lowcnt, TRG_W);
        chk("trig_d9_skew", skew, 0);
        chk("trig_d9_release", 32'(bus.TRG_D9_N), 1);
        chk("score_clr_first", 32'(sc_first), 1);
        chk("score_clr_total", sc_tot, 1);
      end
    end else begin
      chk("no_trig", 32'(fired), 0);
      chk("stay_attract", 32'(bus.ATTRACT_N), 0);
    end
    bus.START_N = 1'b1;
    bus.COIN_N  = 1'b1;
    if (with_coin && !(exp_fire && !m_fp)) m_credits = sat_inc(m_credits);
    else if (exp_fire && !m_fp && with_coin && m_credits == CMAX) m_credits = CMAX - 1;
    else if (exp_fire && !m_fp && !with_coin) m_credits = m_credits - 1;
    if (!exp_fire) tick(D + 4);
    chk("credits_after_start", 32'(bus.CREDITS), m_credits);
  endtask

  // Entered in the first WAIT_ACK cycle; finishes with the controller back in attract.
  task automatic run_game(input bit by_play, input bit coin_in_go);
    int go_entry;
    if (by_play) begin
      bus.C9_OUT = 1'b1;
      tick(1);
      chk("game_on_before_ack", 32'(bus.GAME_ON), 0);
      tick(1);
      chk("game_on_after_ack", 32'(bus.GAME_ON), 1);
      bus.START_N = 1'b0;
      tick(D + 6);
      chk("start_ignored_trg", 32'(bus.TRG_C9_N), 1);
      chk("start_ignored_play", 32'(bus.GAME_ON), 1);
      bus.START_N = 1'b1;
      tick($urandom_range(D + 4, 40));
      bus.C9_OUT = 1'b0;
      tick(1);
      chk("game_on_at_c9_sample", 32'(bus.GAME_ON), 1);
      tick(1);
      chk("game_on_after_c9_fall", 32'(bus.GAME_ON), 0);
      go_entry = cyc;
    end else begin
      go_entry = cyc + ACK_TO;
      tick(ACK_TO + 2);
      bus.C9_OUT = 1'b1;
      tick(3);
      chk("timeout_no_play", 32'(bus.GAME_ON), 0);
      bus.C9_OUT = 1'b0;
    end
    if (coin_in_go) coin_press($urandom_range(D + 4, 60), 1'b0);
    wait_until(go_entry + GO_CYC - 1);
    chk("game_over_hold", 32'(bus.ATTRACT_N), 1);
    tick(1);
    chk("back_to_attract", 32'(bus.ATTRACT_N), 0);
    chk("credits_after_game", 32'(bus.CREDITS), m_credits);
  endtask

  initial begin
    bit exp_fire;
    rst = 1'b1;
    bus.COIN_N = 1'b1;
    bus.START_N = 1'b1;
    bus.FREE_PLAY = 1'b0;
    bus.C9_OUT = 1'b0;
    tick(3);
    chk("rst_trg_c9", 32'(bus.TRG_C9_N), 1);
    chk("rst_trg_d9", 32'(bus.TRG_D9_N), 1);
    chk("rst_attract_n", 32'(bus.ATTRACT_N), 0);
    chk("rst_game_on", 32'(bus.GAME_ON), 0);
    chk("rst_score_clr", 32'(bus.SCORE_CLR), 0);
    chk("rst_credits", 32'(bus.CREDITS), 0);
    rst = 1'b0;
    tick(2);

    coin_press(40, 1'b0);
    coin_press(40, 1'b0);
    coin_press(10, 1'b1);
    coin_press($urandom_range(1, D - 4), 1'b1);

    try_start(1'b1, 1'b0);
    run_game(1'b1, 1'b0);
    try_start(1'b1, 1'b0);
    run_game(1'b0, 1'b1);
    try_start(1'b1, 1'b0);
    run_game(1'b1, 1'b0);
    try_start(1'b0, 1'b0);

    m_fp = 1'b1;
    bus.FREE_PLAY = 1'b1;
    try_start(1'b1, 1'b0);
    run_game(1'b1, 1'b0);
    m_fp = 1'b0;
    bus.FREE_PLAY = 1'b0;

    repeat (12) coin_press($urandom_range(D + 4, 60), 1'b0);
    chk("credits_saturated", 32'(bus.CREDITS), CMAX);
    try_start(1'b1, 1'b1);
    run_game(1'b0, 1'b0);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_credits = 0;
    tick(2);
    chk("credits_cleared", 32'(bus.CREDITS), 0);
    repeat (5) coin_press($urandom_range(D + 4, 60), 1'b0);
    try_start(1'b1, 1'b1);
    run_game(1'b0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      m_fp = 1'($urandom_range(0, 1));
      bus.FREE_PLAY = m_fp;
      repeat ($urandom_range(0, 2)) coin_press($urandom_range(D + 4, 60), 1'b0);
      exp_fire = (m_credits > 0) || m_fp;
      try_start(exp_fire, 1'b0);
      if (exp_fire) run_game(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    m_fp = 1'b0;
    bus.FREE_PLAY = 1'b0;

    repeat (2) coin_press(40, 1'b0);
    try_start(1'b1, 1'b0);
    bus.C9_OUT = 1'b1;
    tick(2);
    chk("play_before_rst", 32'(bus.GAME_ON), 1);
    rst = 1'b1;
    tick(1);
    chk("midrst_trg_c9", 32'(bus.TRG_C9_N), 1);
    chk("midrst_trg_d9", 32'(bus.TRG_D9_N), 1);
    chk("midrst_attract_n", 32'(bus.ATTRACT_N), 0);
    chk("midrst_game_on", 32'(bus.GAME_ON), 0);
    chk("midrst_score_clr", 32'(bus.SCORE_CLR), 0);
    chk("midrst_credits", 32'(bus.CREDITS), 0);
    rst = 1'b0;
    bus.C9_OUT = 1'b0;
    tick(3);
    chk("attract_after_midrst", 32'(bus.ATTRACT_N), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
